// File: rtl/juego_pkg.sv
// Shared types and constants for the turn controller: FSM states, winner codes,
// board width and piece colours.
package juego_pkg;

    typedef enum logic [2:0] {
        ESPERA_INICIO,
        TURNO,
        ESCRIBIR,
        EVALUAR,
        FIN
    } estado_turno_t;

    localparam logic [1:0] GANADOR_NINGUNO  = 2'b00;
    localparam logic [1:0] GANADOR_ROJO     = 2'b01;
    localparam logic [1:0] GANADOR_AMARILLO = 2'b10;
    localparam logic [1:0] GANADOR_EMPATE   = 2'b11;

    localparam int NUM_COLUMNAS = 7;

    localparam logic COLOR_ROJO     = 1'b0;
    localparam logic COLOR_AMARILLO = 1'b1;

    function automatic logic [1:0] ganador_de(input logic color);
        return (color == COLOR_AMARILLO) ? GANADOR_AMARILLO : GANADOR_ROJO;
    endfunction

endpackage

// File: rtl/detector_flanco.sv
// Two-flop register on a raw level input; emits a one-cycle pulse per rising edge.
module detector_flanco (
    input  logic clk,
    input  logic reset,
    input  logic senal_i,
    output logic flanco_o
);

    logic ff1_q, ff2_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ff1_q <= 1'b0;
            ff2_q <= 1'b0;
        end else begin
            ff1_q <= senal_i;
            ff2_q <= ff1_q;
        end
    end

    assign flanco_o = ff1_q & ~ff2_q;

endmodule

// File: rtl/controlador_turnos.sv
// Turn controller for a two-player drop game. Define TEMPORIZADOR_TURNO_EN to
// enable the per-turn countdown; otherwise turns never expire.
module controlador_turnos
    import juego_pkg::*;
#(
    parameter int TIEMPO_TURNO = 10,
    parameter int NUM_COLUMNAS = juego_pkg::NUM_COLUMNAS
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       listo,
    input  logic       jugador_inicial,
    input  logic       boton_jugar,
    input  logic [2:0] columna_sel,
    input  logic       tick_1hz,
    input  logic       tablero_ack,
    input  logic       tablero_rechazo,
    input  logic       hay_ganador,
    input  logic       tablero_lleno,
    output logic       escribir_ficha,
    output logic [2:0] columna_out,
    output logic       jugador_actual,
    output logic [3:0] tiempo_restante,
    output logic       juego_terminado,
    output logic [1:0] ganador
);

    localparam logic [3:0] TIEMPO_INI = 4'(TIEMPO_TURNO);

    estado_turno_t estado_q, estado_d;
    logic [2:0]    columna_q, columna_d;
    logic          jugador_q, jugador_d;
    logic [1:0]    ganador_q, ganador_d;
    logic          pulso_jugar;
    logic          jugada;

    detector_flanco u_flanco_jugar (
        .clk      (clk),
        .reset    (reset),
        .senal_i  (boton_jugar),
        .flanco_o (pulso_jugar)
    );

    assign jugada = pulso_jugar && (int'(columna_sel) < NUM_COLUMNAS);

`ifdef TEMPORIZADOR_TURNO_EN
    logic [3:0] tiempo_q, tiempo_d;
`else
    logic unused_tick;
    assign unused_tick = tick_1hz;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado_q  <= ESPERA_INICIO;
            columna_q <= 3'd0;
            jugador_q <= COLOR_ROJO;
            ganador_q <= GANADOR_NINGUNO;
`ifdef TEMPORIZADOR_TURNO_EN
            tiempo_q  <= TIEMPO_INI;
`endif
        end else begin
            estado_q  <= estado_d;
            columna_q <= columna_d;
            jugador_q <= jugador_d;
            ganador_q <= ganador_d;
`ifdef TEMPORIZADOR_TURNO_EN
            tiempo_q  <= tiempo_d;
`endif
        end
    end

    always_comb begin
        estado_d  = estado_q;
        columna_d = columna_q;
        jugador_d = jugador_q;
        ganador_d = ganador_q;
`ifdef TEMPORIZADOR_TURNO_EN
        tiempo_d  = tiempo_q;
`endif
        case (estado_q)
            ESPERA_INICIO: begin
                if (listo) begin
                    estado_d  = TURNO;
                    jugador_d = jugador_inicial;
`ifdef TEMPORIZADOR_TURNO_EN
                    tiempo_d  = TIEMPO_INI;
`endif
                end
            end
            TURNO: begin
                // A valid play beats an expiring tick in the same cycle.
                if (jugada) begin
                    estado_d  = ESCRIBIR;
                    columna_d = columna_sel;
                end
`ifdef TEMPORIZADOR_TURNO_EN
                else if (tick_1hz) begin
                    if (tiempo_q <= 4'd1) begin
                        jugador_d = ~jugador_q;
                        tiempo_d  = TIEMPO_INI;
                    end else begin
                        tiempo_d  = tiempo_q - 4'd1;
                    end
                end
`endif
            end
            ESCRIBIR: begin
                if (tablero_ack) begin
                    estado_d = EVALUAR;
                end else if (tablero_rechazo) begin
                    estado_d = TURNO;
                end
            end
            EVALUAR: begin
                if (hay_ganador) begin
                    estado_d  = FIN;
                    ganador_d = ganador_de(jugador_q);
                end else if (tablero_lleno) begin
                    estado_d  = FIN;
                    ganador_d = GANADOR_EMPATE;
                end else begin
                    estado_d  = TURNO;
                    jugador_d = ~jugador_q;
`ifdef TEMPORIZADOR_TURNO_EN
                    tiempo_d  = TIEMPO_INI;
`endif
                end
            end
            FIN: begin
            end
            default: estado_d = ESPERA_INICIO;
        endcase
    end

    assign escribir_ficha  = (estado_q == ESCRIBIR);
    assign columna_out     = columna_q;
    assign jugador_actual  = jugador_q;
    assign juego_terminado = (estado_q == FIN);
    assign ganador         = ganador_q;
`ifdef TEMPORIZADOR_TURNO_EN
    assign tiempo_restante = tiempo_q;
`else
    assign tiempo_restante = TIEMPO_INI;
`endif

endmodule

// File: tb/tb_controlador_turnos.sv
// Directed bench for controlador_turnos; drop requests and game results are
// checked by a queue-based scoreboard, state snapshots by direct checks.
module tb_controlador_turnos;

`ifdef TEMPORIZADOR_TURNO_EN
    localparam int T_TURNO = 3;
`else
    localparam int T_TURNO = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       listo = 1'b0;
    logic       jugador_inicial = 1'b0;
    logic       boton_jugar = 1'b0;
    logic [2:0] columna_sel = 3'd0;
    logic       tick_1hz = 1'b0;
    logic       tablero_ack = 1'b0;
    logic       tablero_rechazo = 1'b0;
    logic       hay_ganador = 1'b0;
    logic       tablero_lleno = 1'b0;
    logic       escribir_ficha;
    logic [2:0] columna_out;
    logic       jugador_actual;
    logic [3:0] tiempo_restante;
    logic       juego_terminado;
    logic [1:0] ganador;

    controlador_turnos #(.TIEMPO_TURNO(T_TURNO), .NUM_COLUMNAS(7)) dut (
        .clk             (clk),
        .reset           (reset),
        .listo           (listo),
        .jugador_inicial (jugador_inicial),
        .boton_jugar     (boton_jugar),
        .columna_sel     (columna_sel),
        .tick_1hz        (tick_1hz),
        .tablero_ack     (tablero_ack),
        .tablero_rechazo (tablero_rechazo),
        .hay_ganador     (hay_ganador),
        .tablero_lleno   (tablero_lleno),
        .escribir_ficha  (escribir_ficha),
        .columna_out     (columna_out),
        .jugador_actual  (jugador_actual),
        .tiempo_restante (tiempo_restante),
        .juego_terminado (juego_terminado),
        .ganador         (ganador)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] col;
        logic       jug;
    } req_t;

    req_t       exp_req[$];
    logic [1:0] exp_gan[$];
    int         checks = 0;
    int         errors = 0;

    // Scoreboard monitor: pops on each new drop request and each game-over.
    initial begin
        logic       prev_escr;
        logic       prev_fin;
        req_t       r;
        logic [1:0] g;
        prev_escr = 1'b0;
        prev_fin  = 1'b0;
        forever begin
            @(negedge clk);
            if (escribir_ficha === 1'b1 && prev_escr !== 1'b1) begin
                checks++;
                if (exp_req.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_request: columna_out=%0d jugador_actual=%0d, required no request",
                             columna_out, jugador_actual);
                end else begin
                    r = exp_req.pop_front();
                    if (columna_out !== r.col || jugador_actual !== r.jug) begin
                        errors++;
                        $display("FAIL request: columna_out=%0d jugador_actual=%0d, required columna=%0d jugador=%0d",
                                 columna_out, jugador_actual, r.col, r.jug);
                    end else begin
                        $display("ok   request: columna=%0d jugador=%0d", r.col, r.jug);
                    end
                end
            end
            if (juego_terminado === 1'b1 && prev_fin !== 1'b1) begin
                checks++;
                if (exp_gan.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_game_over: ganador=%0d, required game running", ganador);
                end else begin
                    g = exp_gan.pop_front();
                    if (ganador !== g) begin
                        errors++;
                        $display("FAIL game_over: ganador=%0d, required %0d", ganador, g);
                    end else begin
                        $display("ok   game_over: ganador=%0d", g);
                    end
                end
            end
            prev_escr = escribir_ficha;
            prev_fin  = juego_terminado;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic push_req(input logic [2:0] col, input logic jug);
        req_t r;
        r.col = col;
        r.jug = jug;
        exp_req.push_back(r);
    endtask

    // Hold the button several cycles; optionally tick in the cycle the edge pulse is seen.
    task automatic press(input logic [2:0] col, input bit tick_same);
        @(posedge clk); #1;
        columna_sel = col;
        boton_jugar = 1'b1;
        @(posedge clk); #1;
        if (tick_same) tick_1hz = 1'b1;
        @(posedge clk); #1;
        tick_1hz = 1'b0;
        repeat (3) @(posedge clk);
        #1 boton_jugar = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    // Board response pulse, then evaluation flags in the following cycle.
    task automatic resp(input logic a, input logic r, input logic h, input logic l);
        @(posedge clk); #1;
        tablero_ack     = a;
        tablero_rechazo = r;
        @(posedge clk); #1;
        tablero_ack     = 1'b0;
        tablero_rechazo = 1'b0;
        hay_ganador     = h;
        tablero_lleno   = l;
        @(posedge clk); #1;
        hay_ganador     = 1'b0;
        tablero_lleno   = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 tick_1hz = 1'b1;
            @(posedge clk); #1 tick_1hz = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_escribir", escribir_ficha, 0);
        check("rst_columna", columna_out, 0);
        check("rst_jugador", jugador_actual, 0);
        check("rst_tiempo", tiempo_restante, T_TURNO);
        check("rst_terminado", juego_terminado, 0);
        check("rst_ganador", ganador, 0);
        reset = 1'b0;
        repeat (2) @(posedge clk);

        // Press before listo is discarded.
        press(3'd3, 0);
        check("espera_no_request", escribir_ficha, 0);
        listo = 1'b1;
        jugador_inicial = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("inicio_jugador", jugador_actual, 1);

        // Column 3 accepted and acknowledged.
        push_req(3'd3, 1'b1);
        press(3'd3, 0);
        check("req_escribir", escribir_ficha, 1);
        check("req_columna", columna_out, 3);
        resp(1'b1, 1'b0, 1'b0, 1'b0);
        check("eval_toggle_jugador", jugador_actual, 0);
        check("eval_tiempo", tiempo_restante, T_TURNO);
        check("eval_escribir_low", escribir_ficha, 0);

        // Rejection keeps the turn; out-of-range column ignored.
        push_req(3'd5, 1'b0);
        press(3'd5, 0);
        resp(1'b0, 1'b1, 1'b0, 1'b0);
        check("rechazo_jugador", jugador_actual, 0);
        check("rechazo_escribir", escribir_ficha, 0);
        press(3'd7, 0);
        check("col7_ignored", escribir_ficha, 0);

        // Ack outside ESCRIBIR ignored; ack wins over simultaneous rechazo.
        resp(1'b1, 1'b0, 1'b1, 1'b0);
        check("ack_turno_terminado", juego_terminado, 0);
        check("ack_turno_jugador", jugador_actual, 0);
        push_req(3'd2, 1'b0);
        press(3'd2, 0);
        resp(1'b1, 1'b1, 1'b0, 1'b0);
        check("ack_over_rechazo_jugador", jugador_actual, 1);

`ifdef TEMPORIZADOR_TURNO_EN
        ticks(2);
        check("timer_after2_tiempo", tiempo_restante, 1);
        check("timer_after2_jugador", jugador_actual, 1);
        ticks(1);
        check("timer_expire_jugador", jugador_actual, 0);
        check("timer_expire_reload", tiempo_restante, 3);
        ticks(2);
        check("timer_at1", tiempo_restante, 1);
        push_req(3'd4, 1'b0);
        exp_gan.push_back(2'b11);
        press(3'd4, 1);
        check("play_and_tick_escribir", escribir_ficha, 1);
        check("play_and_tick_no_toggle", jugador_actual, 0);
`else
        ticks(15);
        check("no_timer_tiempo", tiempo_restante, 10);
        check("no_timer_jugador", jugador_actual, 1);
        push_req(3'd4, 1'b1);
        exp_gan.push_back(2'b11);
        press(3'd4, 0);
        check("lleno_req_escribir", escribir_ficha, 1);
`endif
        resp(1'b1, 1'b0, 1'b0, 1'b1);
        check("empate_terminado", juego_terminado, 1);
        check("empate_ganador", ganador, 3);

        // Reset while a request is pending.
        jugador_inicial = 1'b0;
        pulse_reset();
        check("restart_jugador", jugador_actual, 0);
        check("restart_ganador", ganador, 0);
        push_req(3'd6, 1'b0);
        press(3'd6, 0);
        check("pending_escribir", escribir_ficha, 1);
        #2 reset = 1'b1;
        #1;
        check("async_rst_escribir", escribir_ficha, 0);
        check("async_rst_columna", columna_out, 0);
        #3 reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("after_rst_no_request", escribir_ficha, 0);
        press(3'd7, 0);
        check("after_rst_col7_ignored", escribir_ficha, 0);

        // Rojo wins; winner has priority over full board; FIN is sticky.
        push_req(3'd1, 1'b0);
        exp_gan.push_back(2'b01);
        press(3'd1, 0);
        resp(1'b1, 1'b0, 1'b1, 1'b1);
        check("rojo_terminado", juego_terminado, 1);
        check("rojo_ganador", ganador, 1);
        press(3'd2, 0);
        resp(1'b1, 1'b0, 1'b0, 1'b0);
        resp(1'b0, 1'b1, 1'b0, 1'b0);
        check("fin_hold_ganador", ganador, 1);
        check("fin_hold_jugador", jugador_actual, 0);
        check("fin_hold_escribir", escribir_ficha, 0);
        check("fin_hold_terminado", juego_terminado, 1);

        // Amarillo wins.
        jugador_inicial = 1'b1;
        pulse_reset();
        push_req(3'd0, 1'b1);
        exp_gan.push_back(2'b10);
        press(3'd0, 0);
        resp(1'b1, 1'b0, 1'b1, 1'b0);
        check("amarillo_ganador", ganador, 2);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("req_queue_drained", exp_req.size(), 0);
        check("gan_queue_drained", exp_gan.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
